// File: rtl/data_mem_unit.sv
// data_mem_unit
//   Multi-cycle data-memory responder for the load/store path. A request
//   (MemRead | MemWrite) sampled in IDLE is latched, held for WAIT_CYCLES
//   wait states, and then performed on an internal little-endian word array
//   at the WAIT-exit edge. The access result is presented in RESP together
//   with a one-cycle done pulse.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array (power of two, >= 4)
//   WAIT_CYCLES : wait states before the access (0..15)
//
// Ports
//   clk      in   clock, rising edge active
//   rst_n    in   asynchronous active-low reset
//   MemRead  in   load request
//   MemWrite in   store request
//   funct3   in   access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr     in   byte address
//   wdata    in   store data (low byte/half used for sb/sh)
//   rdata    out  registered load result (0 for stores and rejected requests)
//   busy     out  stall request to the datapath
//   done     out  one-cycle completion pulse
//   err      out  request rejected; meaningful only while done is high
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;

  logic              rd_q;
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              req;
  logic              access;
  logic              acc_err;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       acc_word;

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  // Extract the addressed byte/half from the word and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  ofs);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {ofs, 3'b000});
    h = 16'(word >> {ofs[1], 4'b0000});
    case (f3)
      3'b000:  return sext8(b);
      3'b001:  return sext16(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Read-modify-write merge: only the addressed lanes take store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  ofs);
    logic [31:0] mask;
    logic [31:0] data;
    case (f3[1:0])
      2'b00: begin
        mask = 32'h0000_00FF << {ofs, 3'b000};
        data = {24'd0, wd[7:0]} << {ofs, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {ofs[1], 4'b0000};
        data = {16'd0, wd[15:0]} << {ofs[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wd;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

  // Rejection rules; misalignment tests only matter for legal sizes since
  // any other funct3 is already illegal.
  function automatic logic req_err(input logic        rd,
                                   input logic        wr,
                                   input logic [2:0]  f3,
                                   input logic [31:0] a);
    logic legal;
    if (wr) legal = f3 inside {3'b000, 3'b001, 3'b010};
    else    legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    return (rd & wr) | ~legal
         | ((f3[1:0] == 2'b01) & a[0])
         | ((f3[1:0] == 2'b10) & (a[1:0] != 2'b00))
         | (a[31:2] >= 30'(DEPTH_WORDS));
  endfunction

  assign req      = MemRead | MemWrite;
  assign access   = (state == S_WAIT) && (cnt == 4'd0);
  assign idx_q    = addr_q[IDX_W+1:2];
  assign acc_word = mem[idx_q];
  assign acc_err  = req_err(rd_q, wr_q, f3_q, addr_q);

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      rdata <= 32'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req) begin
        rd_q <= MemRead;
        wr_q <= MemWrite;
      end
      if (access) begin
        err   <= acc_err;
        rdata <= (acc_err || !rd_q) ? 32'd0 : load_ext(acc_word, f3_q, addr_q[1:0]);
      end
    end
  end

  // Request operands, captured with the request
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      f3_q    <= funct3;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Array write at the WAIT-exit edge; reset forces IDLE so an interrupted
  // store never reaches this point.
  always_ff @(posedge clk) begin
    if (access && wr_q && !acc_err) begin
      mem[idx_q] <= store_merge(acc_word, wdata_q, f3_q, addr_q[1:0]);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = req;
        if (req) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset must silence busy even while a request is still being driven.
    if (!rst_n) busy = 1'b0;
  end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  localparam int DEPTH = 256;
  localparam int W2    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;

  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [2:0]  f3_a = 3'd0;
  logic [31:0] addr_a = 32'd0, wd_a = 32'd0;
  logic [31:0] rdata_a;
  logic        busy_a, done_a, err_a;

  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [2:0]  f3_b = 3'd0;
  logic [31:0] addr_b = 32'd0, wd_b = 32'd0;
  logic [31:0] rdata_b;
  logic        busy_b, done_b, err_b;

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .MemRead(rd_a), .MemWrite(wr_a), .funct3(f3_a),
    .addr(addr_a), .wdata(wd_a), .rdata(rdata_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .MemRead(rd_b), .MemWrite(wr_b), .funct3(f3_b),
    .addr(addr_b), .wdata(wd_b), .rdata(rdata_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t xa, xb;

  // Byte-addressed reference memory, one bank per DUT.
  byte unsigned mdl [2][DEPTH*4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model(input int bank, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd,
                                output logic [31:0] r, output logic e);
    int     size;
    bit     uns;
    longint v;
    size = 0; uns = 0; r = 32'd0; e = 1'b0;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1; end
      3'd5: begin size = 2; uns = 1; end
      default: size = 0;
    endcase
    if (rd && wr)                       e = 1'b1;
    else if (size == 0 || (wr && uns))  e = 1'b1;
    else if ((a % 32'(size)) != 0)      e = 1'b1;
    else if ((a / 4) >= 32'(DEPTH))     e = 1'b1;
    if (!e) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mdl[bank][a + 32'(i)] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (longint'(mdl[bank][a + 32'(i)]) << (8*i));
        if (!uns && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
        r = v[31:0];
      end
    end
  endfunction

  task automatic op_a(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    exp_t x;
    int   k;
    @(posedge clk); #1;
    model(0, rd, wr, f3, a, wd, x.rdata, x.err);
    x.due = cyc + W2 + 2;
    q_a.push_back(x);
    rd_a = rd; wr_a = wr; f3_a = f3; addr_a = a; wd_a = wd;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!done_a && k < W2 + 10);
    if (!done_a) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_a: actual=no done required=done within %0d cycles", W2 + 10);
      void'(q_a.pop_back());
    end
    rd_a = 1'b0; wr_a = 1'b0;
  endtask

  // Scoreboard monitor for the WAIT_CYCLES=2 instance
  int busy_run_a = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run_a = 0;
    end else begin
      if (busy_a) busy_run_a++;
      if (done_a) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done_a: actual=done required=no done (cycle %0d)", cyc);
        end else begin
          xa = q_a.pop_front();
          chk("rdata_a", rdata_a, xa.rdata);
          chk("err_a", 32'(err_a), 32'(xa.err));
          chk("latency_a", cyc, xa.due);
          chk("busy_len_a", busy_run_a, W2 + 2);
        end
        busy_run_a = 0;
      end
    end
  end

  // Scoreboard monitor for the zero-wait instance
  always @(negedge clk) begin
    if (rst_n && done_b) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done_b: actual=done required=no done (cycle %0d)", cyc);
      end else begin
        xb = q_b.pop_front();
        chk("rdata_b", rdata_b, xb.rdata);
        chk("err_b", 32'(err_b), 32'(xb.err));
        chk("latency_b", cyc, xb.due);
      end
    end
  end

  logic        ch_wr [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0]  ch_f3 [6] = '{3'd2, 3'd1, 3'd2, 3'd0, 3'd5, 3'd2};
  logic [31:0] ch_a  [6] = '{32'h10, 32'h12, 32'h10, 32'h13, 32'h12, 32'h400};
  logic [31:0] ch_d  [6] = '{32'h1122_3344, 32'h0000_BEEF, 32'd0, 32'd0, 32'd0, 32'd0};

  // Requests held high continuously; operands change in each done cycle.
  task automatic chain_b();
    exp_t x;
    int   k;
    int   issue;
    @(posedge clk); #1;
    issue = cyc;
    for (int i = 0; i < 6; i++) begin
      model(1, !ch_wr[i], ch_wr[i], ch_f3[i], ch_a[i], ch_d[i], x.rdata, x.err);
      x.due = issue + 2;
      q_b.push_back(x);
      rd_b = !ch_wr[i]; wr_b = ch_wr[i]; f3_b = ch_f3[i]; addr_b = ch_a[i]; wd_b = ch_d[i];
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!done_b && k < 10);
      if (!done_b) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout_b: actual=no done required=done within 10 cycles");
        void'(q_b.pop_back());
      end
      issue = cyc + 1;
    end
    rd_b = 1'b0; wr_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3tab [6];
    f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_done", 32'(done_a), 32'd0);

    // Directed: round trip, sub-word, misalignment, illegal requests
    op_a(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF);
    op_a(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
    op_a(1'b0, 1'b1, 3'd0, 32'h101, 32'h0000_0080);
    op_a(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
    op_a(1'b1, 1'b0, 3'd0, 32'h101, 32'd0);
    op_a(1'b1, 1'b0, 3'd4, 32'h101, 32'd0);
    op_a(1'b1, 1'b0, 3'd5, 32'h102, 32'd0);
    op_a(1'b0, 1'b1, 3'd1, 32'h103, 32'h0000_5555);
    op_a(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
    op_a(1'b1, 1'b0, 3'd2, 32'h400, 32'd0);
    op_a(1'b1, 1'b1, 3'd2, 32'h100, 32'h0000_0000);
    op_a(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
    op_a(1'b1, 1'b0, 3'd3, 32'h100, 32'd0);

    // Reset while in WAIT with one wait state left
    op_a(1'b0, 1'b1, 3'd2, 32'h200, 32'hCAFE_F00D);
    op_a(1'b1, 1'b0, 3'd2, 32'h200, 32'd0);
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b1; f3_a = 3'd2; addr_a = 32'h200; wd_a = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdata", rdata_a, 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    chk("midrst_err", 32'(err_a), 32'd0);
    wr_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    op_a(1'b1, 1'b0, 3'd2, 32'h200, 32'd0);

    // Randomized traffic over an initialised window
    for (int i = 0; i < 16; i++) op_a(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom);
    for (int n = 0; n < 60; n++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          s;
      s  = int'($urandom_range(0, 19));
      wr = 1'($urandom_range(0, 1));
      rd = !wr;
      if (s == 0) begin rd = 1'b1; wr = 1'b1; end
      f3 = f3tab[$urandom_range(0, 5)];
      if (s == 1) f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 63));
      if (s == 2) a = 32'h400 + 32'($urandom_range(0, 63));
      if (s == 3) a = $urandom | 32'h8000_0000;
      op_a(rd, wr, f3, a, $urandom);
    end

    // Zero-wait back-to-back
    chain_b();

    repeat (4) @(posedge clk);
    #1;
    chk("q_a_left", 32'(q_a.size()), 32'd0);
    chk("q_b_left", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Multi-cycle data-memory responder for the datapath's load/store path. It receives the `MemRead`/`MemWrite` strobes produced by opcode decode, together with the ALU address, `funct3` and store data. It performs byte, half or word accesses on an internal little-endian word array after a programmable number of wait states. It stalls the datapath with `busy` and completes each access with a one-cycle `done` pulse, flagging misaligned, out-of-range or malformed requests with `err`.

## Interface
- `DEPTH_WORDS`, 256 — number of 32-bit words in the array; power of two, at least 4.
- `WAIT_CYCLES`, 2 — wait states inserted before the access; range 0..15.
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `MemRead`  in  1  — load request, from decode.
- `MemWrite`  in  1  — store request, from decode.
- `funct3`  in  3  — access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `addr`  in  32  — byte address (ALU result).
- `wdata`  in  32  — store data (rs2); low byte/half used for sb/sh.
- `rdata`  out  32  — load result, sign- or zero-extended; registered.
- `busy`  out  1  — stall request to the datapath.
- `done`  out  1  — one-cycle completion pulse.
- `err`  out  1  — valid only with `done`; request was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. A request is `MemRead | MemWrite`.
- **IDLE**
  - On an edge where a request is present: latch `addr`, `funct3`, `wdata` and the operation.
  - Load the wait counter with `WAIT_CYCLES`; next state is WAIT.
  - Requests are sampled only in IDLE.
- **WAIT**
  - If the counter is nonzero, decrement it.
  - If the counter is 0: perform the access at this edge, register `rdata` and `err`, and go to RESP.
- **RESP**
  - `done` = 1 for exactly one cycle; next state is IDLE unconditionally.
- **Error checks**, evaluated on the latched request. On error: no array write, `rdata` = 0, `err` = 1.
  - `MemRead` and `MemWrite` both high.
  - `funct3` not in the legal set for the operation. Loads: 000, 001, 010, 100, 101. Stores: 000, 001, 010.
  - Halfword access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 00.
  - `addr[31:2]` ≥ `DEPTH_WORDS`.
- **Loads**
  - Select the byte/half by `addr[1:0]` (little-endian).
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw returns the whole word.
- **Stores**
  - Read-modify-write of the addressed word.
  - sb writes `wdata[7:0]` to lane `addr[1:0]`.
  - sh writes `wdata[15:0]` to lane `addr[1]`.
  - sw writes the full word. Other lanes are unchanged.
- **Requester obligations**
  - Hold the request and operands until `done`.
  - Drop the request in the `done` cycle. A request still high in the cycle after RESP starts a new access.
- **Reset**
  - Forces IDLE; `rdata` = 0, `busy` = 0, `done` = 0, `err` = 0, wait counter = 0.
  - Array contents are not reset.
  - A store interrupted by reset before its access edge is discarded and leaves memory unchanged.

## Timing
- **busy**
  - Combinational: (IDLE and request present) or WAIT.
  - Low in RESP, so the datapath advances in the `done` cycle.
- **Latency**
  - Request first present in cycle c (state IDLE) → `done` high in cycle c + `WAIT_CYCLES` + 2.
  - `busy` is high for cycles c through c + `WAIT_CYCLES` + 1.
- **Outputs**
  - `rdata` and `err` change only at the access edge and hold until the next access edge.
  - `done` is high only in RESP.
- **Throughput**: at most one access per `WAIT_CYCLES` + 3 cycles; the minimum gap is one IDLE cycle.
- **Memory write** occurs exactly at the WAIT-exit edge; a load issued afterwards sees the new data.
- **Reset**: asynchronous assertion takes effect immediately in any state; deassertion is sampled at the next clock edge.

## Test plan
- **sw/lw round trip**
  - `WAIT_CYCLES` = 2: sw 0xDEADBEEF at 0x100 in cycle 0 → `done` in cycle 4 with `err` = 0.
  - lw from 0x100 → `rdata` = 0xDEADBEEF with `done` 4 cycles after request; `busy` high exactly 4 cycles.
- **Sub-word access and extension**
  - sb 0x80 at 0x101, then lw 0x100 → 0xDEAD80EF.
  - lb 0x101 → 0xFFFFFF80; lbu 0x101 → 0x00000080; lhu 0x102 → 0x0000DEAD.
- **Misalignment**
  - sh at 0x103 → `done` with `err` = 1, `rdata` = 0.
  - lw 0x100 afterwards is still 0xDEAD80EF, confirming no write occurred.
- **Out-of-range and illegal requests**
  - `DEPTH_WORDS` = 256: lw 0x400 → `err` = 1.
  - `MemRead` and `MemWrite` both high → `err` = 1, no write.
  - Load with `funct3` = 011 → `err` = 1.
- **Reset mid-operation**
  - sw 0x12345678 to 0x200; assert `rst_n` low while in WAIT with counter 1.
  - All outputs go 0 immediately; after release, lw 0x200 returns the prior contents.
- **Zero-wait and back-to-back**
  - `WAIT_CYCLES` = 0: `done` 2 cycles after request.
  - Request held high through `done` → second access starts in the next cycle; `done` pulses every 3 cycles.
